keypad_digit_entry: RTL
=======================

Name: keypad_digit_entry

Overview:
- Parametrised successor to the combinational 10-key priority encoder in the timer-entry path.
- Synchronises and priority-encodes a raw NUM_KEYS keypad, debounces press and release, and emits one code per physical press.
- Shifts accepted digits into a DIGITS-deep BCD entry register that feeds the timer loader.
- Includes a press/release state machine, digit count, full and overflow signalling, and leading-zero suppression.

Parameters:
- NUM_KEYS, 10, number of key lines (2..16); key i encodes to code i.
- DIGITS, 4, depth of the digit entry register (1..8).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a press or a release (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  entry enable; low forces state IDLE and blocks acceptance.
- clear  input  1  synchronous clear of the digit register and count.
- keys  input  NUM_KEYS  raw asynchronous key lines, active-high.
- any_key  output  1  synchronised OR of all keys (undebounced).
- key_valid  output  1  one-cycle pulse per accepted press.
- key_code  output  4  code of the last accepted key; held between pulses.
- digits  output  4*DIGITS  BCD entry; [3:0] is the newest digit.
- count  output  $clog2(DIGITS+1)  number of digits entered.
- full  output  1  count == DIGITS.
- overflow  output  1  one-cycle pulse when a press is discarded because full.

Behaviour:
- Reset: all outputs 0, synchroniser flops 0, FSM in IDLE, debounce counter 0.
- Input path:
  - keys pass through a 2-flop synchroniser.
  - Priority encoder on the synchronised vector: highest set index wins; all-zero gives code 0 with hit=0.
  - any_key = hit, registered.
- Debounce counter width: $clog2(DEBOUNCE_CYCLES+1).
- FSM states:
  - IDLE: hit=1 -> DEBOUNCE; latch cand=code; cnt=1.
  - DEBOUNCE:
    - hit=0 -> IDLE.
    - code!=cand -> cand=code, cnt=1.
    - Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES -> ACCEPT.
  - ACCEPT (one cycle): key_valid=1, key_code=cand, perform the entry action -> HELD.
  - HELD: hit=0 -> RELEASE with cnt=1; a code change while held is ignored.
  - RELEASE:
    - hit=1 -> HELD, with no new accept.
    - Otherwise cnt++. At DEBOUNCE_CYCLES -> IDLE.
- Latency: key_valid pulses exactly DEBOUNCE_CYCLES+3 rising edges after the first edge at which a key is high and stable at the keys pins.
- Entry action on ACCEPT:
  - Code 0 with count==0 (leading zero): key_valid still pulses; digits and count are unchanged.
  - Code >9 (NUM_KEYS>10): key_valid pulses with the code; digits and count are unchanged (function keys).
  - full=1 and a digit code: digits unchanged, overflow pulses together with key_valid.
  - Otherwise: digits <= {digits[4*DIGITS-5:0], code}; count++.
- clear:
  - digits=0, count=0 on the next edge.
  - If clear coincides with ACCEPT, clear wins: no shift, but key_valid still pulses.
  - The FSM is not affected by clear.
- en low:
  - FSM returns to IDLE and the counter zeroes; no key_valid or overflow.
  - digits and count are held.
  - A key still held when en rises is treated as a fresh press.
- full is combinational from count; any_key is unaffected by en.
- Reset asserted mid-press: everything returns to reset values immediately; no pulse is produced after deassertion until a full debounce completes.

Optional Feature:
- Macro: KEYPAD_MULTIKEY_REJECT_EN.
- Defined:
  - In DEBOUNCE, more than one synchronised key high restarts the state to IDLE, so no acceptance can occur while multiple keys are pressed.
  - In HELD, multiple keys are treated as held.
- Undefined: normal priority encoding; the highest index wins.

Test Plan:
- DEBOUNCE_CYCLES=4, DIGITS=4, en=1: press key 5 for 20 cycles, then release for 20 -> one key_valid, 7 edges after press; key_code=5; digits=16'h0005; count=1.
- Press 1, 2, 3, 4, 5 in sequence (each held 10 cycles, released 10) -> digits=16'h1234 after the fourth press, full=1; fifth press gives key_valid plus overflow, digits unchanged.
- From reset, press 0, then 7 -> both give key_valid; after 0, count=0; after 7, digits=16'h0007, count=1.
- Key 3 bouncing high/low every 2 cycles for 12 cycles, then stable -> exactly one key_valid, after the stable window; a 2-cycle release glitch while held gives no second pulse.
- Keys 2 and 8 pressed together -> key_code=8 without the macro; no key_valid with KEYPAD_MULTIKEY_REJECT_EN defined.
- clear asserted on the same edge as ACCEPT of key 9 with count=2 -> key_valid=1, digits=0, count=0; drop en mid-debounce -> no pulse.

Source files
------------

// File: rtl/keypad_digit_entry.sv
// Keypad front end: 2-flop synchroniser, priority encoder, press/release debounce FSM
// and a BCD digit entry shift register. Define KEYPAD_MULTIKEY_REJECT_EN to reject chords.
module keypad_digit_entry #(
  parameter int NUM_KEYS        = 10,
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          clear,
  input  logic [NUM_KEYS-1:0]           keys,
  output logic                          any_key,
  output logic                          key_valid,
  output logic [3:0]                    key_code,
  output logic [4*DIGITS-1:0]           digits,
  output logic [$clog2(DIGITS+1)-1:0]   count,
  output logic                          full,
  output logic                          overflow
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DIGITS_C = CW'(DIGITS);
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] CNT_ONE  = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_ACCEPT,
    S_HELD,
    S_RELEASE
  } state_e;

  state_e               state_q;
  logic [NUM_KEYS-1:0]  sync1_q, sync2_q;
  logic [DW-1:0]        cnt_q;
  logic [3:0]           cand_q;
  logic [3:0]           key_code_q;
  logic                 any_key_q, key_valid_q, overflow_q;
  logic [4*DIGITS-1:0]  digits_q, digits_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_d;

  logic [3:0]           code;
  logic                 hit;
  logic                 multi;
  logic                 accept_fire;
  logic [4*DIGITS+3:0]  shift_ext;

  // Priority encoder: later (higher) indices overwrite earlier ones.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    code = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sync2_q[i]) code = 4'(i);
    end
  end

  assign hit = |sync2_q;

`ifdef KEYPAD_MULTIKEY_REJECT_EN
  assign multi = |(sync2_q & (sync2_q - 1'b1));
`else
  assign multi = 1'b0;
`endif

  assign accept_fire = en && (state_q == S_ACCEPT);
  assign shift_ext   = {digits_q, cand_q};

  // Entry action; clear takes priority over the shift but not over the key_valid pulse.
  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    ovf_d    = 1'b0;
    if (accept_fire && cand_q <= 4'd9 && !(cand_q == 4'd0 && count_q == '0)) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        digits_d = shift_ext[4*DIGITS-1:0];
        count_d  = count_q + 1'b1;
      end
    end
    if (clear) begin
      digits_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      any_key_q   <= 1'b0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      digits_q    <= '0;
      count_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync1_q     <= keys;
      sync2_q     <= sync1_q;
      any_key_q   <= hit;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      digits_q    <= digits_d;
      count_q     <= count_d;

      if (!en) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (hit) begin
              cand_q  <= code;
              cnt_q   <= CNT_ONE;
              state_q <= (DEBOUNCE_CYCLES == 1) ? S_ACCEPT : S_DEBOUNCE;
            end
          end
          S_DEBOUNCE: begin
            if (!hit || multi) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
            end else if (code != cand_q) begin
              cand_q <= code;
              cnt_q  <= CNT_ONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q >= CNT_LAST) state_q <= S_ACCEPT;
            end
          end
          S_ACCEPT: begin
            key_valid_q <= 1'b1;
            key_code_q  <= cand_q;
            overflow_q  <= ovf_d;
            cnt_q       <= '0;
            state_q     <= S_HELD;
          end
          S_HELD: begin
            if (!hit) begin
              cnt_q   <= CNT_ONE;
              state_q <= (DEBOUNCE_CYCLES == 1) ? S_IDLE : S_RELEASE;
            end
          end
          S_RELEASE: begin
            if (hit) begin
              cnt_q   <= '0;
              state_q <= S_HELD;
            end else if (cnt_q >= CNT_LAST) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign any_key   = any_key_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign digits    = digits_q;
  assign count     = count_q;
  assign full      = (count_q == DIGITS_C);
  assign overflow  = overflow_q;

endmodule
